// File: rtl/vga_timing_pkg.sv
// ============================================================================
// Module      : vga_timing_pkg
// Description : Default 640x480@60 timing constants and a shared window test
//               used by the timing generator and the display-side modules.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_timing_pkg;

    localparam int c_CNT_W     = 10;

    localparam int c_H_VISIBLE = 640;
    localparam int c_H_FP      = 16;
    localparam int c_H_SYNC    = 96;
    localparam int c_H_BP      = 48;
    localparam int c_H_TOTAL   = c_H_VISIBLE + c_H_FP + c_H_SYNC + c_H_BP;

    localparam int c_V_VISIBLE = 480;
    localparam int c_V_FP      = 10;
    localparam int c_V_SYNC    = 2;
    localparam int c_V_BP      = 33;
    localparam int c_V_TOTAL   = c_V_VISIBLE + c_V_FP + c_V_SYNC + c_V_BP;

    // True when lo <= v < lo+len.
    function automatic logic in_window(input logic [c_CNT_W-1:0] v,
                                       input int                  lo,
                                       input int                  len);
        return (int'(v) >= lo) && (int'(v) < lo + len);
    endfunction

endpackage

`default_nettype wire

// File: rtl/clk_en_div.sv
// ============================================================================
// Module      : clk_en_div
// Description : Free-running 0..DIV-1 divider producing a clock-enable tick
//               on the last count; synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_en_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam logic [3:0] c_LAST = 4'(DIV - 1);

    logic [3:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr || (r_cnt == c_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    assign tick = (r_cnt == c_LAST);

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module      : vga_timing_gen
// Description : VGA raster timing: pixel enable, x/y position, active-video
//               flag, active-low syncs and line/frame start pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int H_VISIBLE = c_H_VISIBLE,
    parameter int H_FP      = c_H_FP,
    parameter int H_SYNC    = c_H_SYNC,
    parameter int H_BP      = c_H_BP,
    parameter int V_VISIBLE = c_V_VISIBLE,
    parameter int V_FP      = c_V_FP,
    parameter int V_SYNC    = c_V_SYNC,
    parameter int V_BP      = c_V_BP
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    output logic               pixel_tick,
    output logic [c_CNT_W-1:0] pixel_x,
    output logic [c_CNT_W-1:0] pixel_y,
    output logic               video_on,
    output logic               hsync,
    output logic               vsync,
    output logic               line_start,
    output logic               frame_start
);

    localparam logic [c_CNT_W-1:0] c_H_LAST = c_CNT_W'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [c_CNT_W-1:0] c_V_LAST = c_CNT_W'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);

    logic               w_tick;
    logic               w_h_wrap;
    logic [c_CNT_W-1:0] w_h_next;
    logic [c_CNT_W-1:0] w_v_next;
    logic [c_CNT_W-1:0] r_h_cnt;
    logic [c_CNT_W-1:0] r_v_cnt;

    clk_en_div #(
        .DIV   (CLK_DIV)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!en),
        .tick  (w_tick)
    );

    always_comb begin
        w_h_wrap = (r_h_cnt == c_H_LAST);
        w_h_next = w_h_wrap ? '0 : r_h_cnt + 1'b1;
        w_v_next = r_v_cnt;
        if (w_h_wrap) begin
            w_v_next = (r_v_cnt == c_V_LAST) ? '0 : r_v_cnt + 1'b1;
        end
    end

    // Decode from the next counter values so every output changes on the same
    // clk as the position it describes; pulses last a single clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_cnt     <= '0;
            r_v_cnt     <= '0;
            pixel_tick  <= 1'b0;
            video_on    <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (!en) begin
            r_h_cnt     <= '0;
            r_v_cnt     <= '0;
            pixel_tick  <= 1'b0;
            video_on    <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pixel_tick  <= w_tick;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (w_tick) begin
                r_h_cnt     <= w_h_next;
                r_v_cnt     <= w_v_next;
                video_on    <= in_window(w_h_next, 0, H_VISIBLE) &&
                               in_window(w_v_next, 0, V_VISIBLE);
                hsync       <= !in_window(w_h_next, H_VISIBLE + H_FP, H_SYNC);
                vsync       <= !in_window(w_v_next, V_VISIBLE + V_FP, V_SYNC);
                line_start  <= (w_h_next == '0);
                frame_start <= (w_h_next == '0) && (w_v_next == '0);
            end
        end
    end

    assign pixel_x = r_h_cnt;
    assign pixel_y = r_v_cnt;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Self-checking bench: default timing at CLK_DIV=4 plus reduced
//               timing at CLK_DIV=4 and CLK_DIV=1 against an elapsed-clock model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_timing_gen;

    localparam int SH_V = 16, SH_FP = 2, SH_S = 4, SH_BP = 3;   // 25 pixels/line
    localparam int SV_V = 8,  SV_FP = 1, SV_S = 2, SV_BP = 2;   // 13 lines/frame

    typedef struct packed {
        logic       tick;
        logic [9:0] x;
        logic [9:0] y;
        logic       vo;
        logic       hs;
        logic       vs;
        logic       ls;
        logic       fs;
    } exp_t;

    localparam logic [25:0] c_RST_VAL = {1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en_ac = 1'b0;
    logic en_b  = 1'b0;

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int nA = 0, nB = 0, nC = 0;
    int win_vo = 0, win_hs = 0, win_vs = 0, win_fs = 0;

    logic       a_tick, a_vo, a_hs, a_vs, a_ls, a_fs;
    logic [9:0] a_x, a_y;
    logic       b_tick, b_vo, b_hs, b_vs, b_ls, b_fs;
    logic [9:0] b_x, b_y;
    logic       c_tick, c_vo, c_hs, c_vs, c_ls, c_fs;
    logic [9:0] c_x, c_y;
    exp_t       gA, gB, gC;

    assign gA = {a_tick, a_x, a_y, a_vo, a_hs, a_vs, a_ls, a_fs};
    assign gB = {b_tick, b_x, b_y, b_vo, b_hs, b_vs, b_ls, b_fs};
    assign gC = {c_tick, c_x, c_y, c_vo, c_hs, c_vs, c_ls, c_fs};

    vga_timing_gen #(.CLK_DIV(4)) u_a (
        .clk(clk), .rst_n(rst_n), .en(en_ac),
        .pixel_tick(a_tick), .pixel_x(a_x), .pixel_y(a_y), .video_on(a_vo),
        .hsync(a_hs), .vsync(a_vs), .line_start(a_ls), .frame_start(a_fs)
    );

    vga_timing_gen #(
        .CLK_DIV(4), .H_VISIBLE(SH_V), .H_FP(SH_FP), .H_SYNC(SH_S), .H_BP(SH_BP),
        .V_VISIBLE(SV_V), .V_FP(SV_FP), .V_SYNC(SV_S), .V_BP(SV_BP)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .en(en_b),
        .pixel_tick(b_tick), .pixel_x(b_x), .pixel_y(b_y), .video_on(b_vo),
        .hsync(b_hs), .vsync(b_vs), .line_start(b_ls), .frame_start(b_fs)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_VISIBLE(SH_V), .H_FP(SH_FP), .H_SYNC(SH_S), .H_BP(SH_BP),
        .V_VISIBLE(SV_V), .V_FP(SV_FP), .V_SYNC(SV_S), .V_BP(SV_BP)
    ) u_c (
        .clk(clk), .rst_n(rst_n), .en(en_ac),
        .pixel_tick(c_tick), .pixel_x(c_x), .pixel_y(c_y), .video_on(c_vo),
        .hsync(c_hs), .vsync(c_vs), .line_start(c_ls), .frame_start(c_fs)
    );

    // Expected outputs after n enabled clks since reset release / en rise.
    function automatic exp_t model(input int n, input int div,
                                   input int hv, input int hf, input int hs, input int hb,
                                   input int vv, input int vf, input int vs, input int vb);
        exp_t e;
        int   p, x, y, ht, vt;
        e    = '0;
        e.hs = 1'b1;
        e.vs = 1'b1;
        ht   = hv + hf + hs + hb;
        vt   = vv + vf + vs + vb;
        if (n >= div) begin
            p      = n / div;
            x      = p % ht;
            y      = (p / ht) % vt;
            e.tick = (n % div == 0);
            e.x    = 10'(x);
            e.y    = 10'(y);
            e.vo   = (x < hv) && (y < vv);
            e.hs   = !((x >= hv + hf) && (x < hv + hf + hs));
            e.vs   = !((y >= vv + vf) && (y < vv + vf + vs));
            e.ls   = e.tick && (x == 0);
            e.fs   = e.ls && (y == 0);
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        nA <= (!rst_n || !en_ac) ? 0 : nA + 1;
        nB <= (!rst_n || !en_b)  ? 0 : nB + 1;
        nC <= (!rst_n || !en_ac) ? 0 : nC + 1;
    end

    always @(negedge clk) begin
        chk("model_a", {6'd0, gA},
            {6'd0, model(rst_n ? nA : 0, 4, 640, 16, 96, 48, 480, 10, 2, 33)});
        chk("model_b", {6'd0, gB},
            {6'd0, model(rst_n ? nB : 0, 4, SH_V, SH_FP, SH_S, SH_BP, SV_V, SV_FP, SV_S, SV_BP)});
        chk("model_c", {6'd0, gC},
            {6'd0, model(rst_n ? nC : 0, 1, SH_V, SH_FP, SH_S, SH_BP, SV_V, SV_FP, SV_S, SV_BP)});
    end

    // Second reduced frame spans enabled clks 1300..2599 on u_b.
    always @(negedge clk) begin
        if (rst_n && en_b && nB >= 1300 && nB < 2600) begin
            if (b_fs) win_fs <= win_fs + 1;
            if (b_tick && b_vo) win_vo <= win_vo + 1;
            if (b_tick && !b_hs) win_hs <= win_hs + 1;
            if (b_tick && !b_vs) win_vs <= win_vs + 1;
        end
    end

    task automatic run_to(input int k);
        int g = 0;
        while (nA < k && g < 20000) begin
            @(negedge clk);
            g++;
        end
        chk("run_to_bound", 32'(nA), 32'(k));
    endtask

    initial begin
        int pulses, fs_cnt, k;
        repeat (3) @(negedge clk);
        chk("reset_state", {6'd0, gA}, {6'd0, c_RST_VAL});
        #1 rst_n = 1'b1; en_ac = 1'b1; en_b = 1'b1;

        run_to(3);    chk("a_tick_clk3", a_tick, 0);
        run_to(4);    chk("a_tick_clk4", a_tick, 1);  chk("a_x_clk4", a_x, 1);
        run_to(5);    chk("a_tick_clk5", a_tick, 0);  chk("a_x_clk5", a_x, 1);
        run_to(1300); chk("b_frame_start", b_fs, 1);  chk("b_line_start", b_ls, 1);
                      chk("b_xy_wrap", {b_x, b_y}, 0);
        run_to(1301); chk("b_fs_one_clk", b_fs, 0);
        run_to(2556); chk("a_vo_639", a_vo, 1);       chk("a_x_639", a_x, 639);
        run_to(2560); chk("a_vo_640", a_vo, 0);       chk("a_x_640", a_x, 640);
        run_to(2600);
        chk("b_vo_per_frame", 32'(win_vo), 128);
        chk("b_hs_low_ticks", 32'(win_hs), 52);
        chk("b_vs_low_ticks", 32'(win_vs), 50);
        chk("b_fs_per_frame", 32'(win_fs), 1);
        run_to(2623); chk("a_hs_655", a_hs, 1);
        run_to(2624); chk("a_hs_656", a_hs, 0);       chk("a_x_656", a_x, 656);
        run_to(3007); chk("a_hs_751", a_hs, 0);
        run_to(3008); chk("a_hs_752", a_hs, 1);
        run_to(3200); chk("a_line_start", a_ls, 1);   chk("a_y_line1", a_y, 1);
                      chk("a_x_line1", a_x, 0);       chk("a_fs_line1", a_fs, 0);

        run_to(3301);
        #1 en_b = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) chk("b_en_low_reset", {6'd0, gB}, {6'd0, c_RST_VAL});
            pulses += int'(b_tick) + int'(b_ls) + int'(b_fs);
        end
        chk("b_en_low_pulses", 32'(pulses), 0);
        #1 en_b = 1'b1;
        fs_cnt = 0;
        for (int i = 0; i < 1299; i++) begin
            @(negedge clk);
            fs_cnt += int'(b_fs);
        end
        chk("b_restart_no_fs", 32'(fs_cnt), 0);
        @(negedge clk);
        chk("b_restart_full_frame_fs", b_fs, 1);

        k = 0;
        while (a_hs !== 1'b0 && k < 4000) begin
            @(negedge clk);
            k++;
        end
        chk("a_hsync_found", 32'(k < 4000), 1);
        #1 rst_n = 1'b0;
        #1 chk("a_async_reset", {6'd0, gA}, {6'd0, c_RST_VAL});
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            chk("c_tick_every_clk", c_tick, 1);
            if (i == 3) chk("a_tick_rerun3", a_tick, 0);
            if (i == 4) chk("a_tick_rerun4", a_tick, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter CLK_DIV, default 4, system clocks per pixel (100 MHz clk -> 25 MHz pixel rate); legal values 1..16.
REQ-002 Parameters H_VISIBLE 640, H_FP 16, H_SYNC 96, H_BP 48: horizontal visible, front porch, sync and back porch widths in pixels; H_TOTAL = sum = 800.
REQ-003 Parameters V_VISIBLE 480, V_FP 10, V_SYNC 2, V_BP 33: the same four widths in lines; V_TOTAL = sum = 525.
REQ-004 Port clk, input, 1: single system clock; all logic on its rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 Port en, input, 1: run enable; low acts as a synchronous soft clear.
REQ-007 Port pixel_tick, output, 1: one-clk pulse per pixel period.
REQ-008 Port pixel_x, output, 10: horizontal position, 0..H_TOTAL-1.
REQ-009 Port pixel_y, output, 10: vertical position, 0..V_TOTAL-1.
REQ-010 Port video_on, output, 1: high only while pixel_x < H_VISIBLE and pixel_y < V_VISIBLE.
REQ-011 Port hsync, output, 1: horizontal sync, active-low.
REQ-012 Port vsync, output, 1: vertical sync, active-low.
REQ-013 Port line_start, output, 1: one-clk pulse when pixel_x becomes 0.
REQ-014 Port frame_start, output, 1: one-clk pulse when pixel_x and pixel_y both become 0.

Function
REQ-015 Divider counter: counts 0..CLK_DIV-1 and wraps; pixel_tick is asserted on the clk where the divider equals CLK_DIV-1; with CLK_DIV=1, pixel_tick is high every clk.
REQ-016 h_cnt advances by 1 only on pixel_tick; at H_TOTAL-1 it wraps to 0 and v_cnt advances on the same tick.
REQ-017 v_cnt wraps from V_TOTAL-1 to 0 on the tick where h_cnt also wraps.
REQ-018 hsync is low iff H_VISIBLE+H_FP <= h_cnt < H_VISIBLE+H_FP+H_SYNC, i.e. 656..751 at defaults.
REQ-019 vsync is low iff V_VISIBLE+V_FP <= v_cnt < V_VISIBLE+V_FP+V_SYNC, i.e. 490..491 at defaults.
REQ-020 All outputs are registered and are derived from the counter values after the update; latency is one clk from a counter change to the matching pixel_x, pixel_y, video_on, hsync, vsync, line_start and frame_start.
REQ-021 pixel_x, pixel_y, video_on, hsync and vsync remain stable for all CLK_DIV clks of a pixel period.
REQ-022 line_start and frame_start pulse for exactly one clk per occurrence, aligned with the first clk of the new pixel_x/pixel_y value, never for CLK_DIV clks.
REQ-023 en low: on the next clk, the divider, h_cnt and v_cnt clear to 0 and all outputs take their reset values; on the first clk with en high, counting resumes from divider 0.
REQ-024 No pixel_tick, line_start or frame_start is emitted while en is low.
REQ-025 When en rises, the first frame_start occurs only after a full frame, not on restart at (0,0).

Reset
REQ-026 rst_n low asynchronously clears the divider, h_cnt and v_cnt to 0.
REQ-027 While rst_n is low: pixel_tick 0, pixel_x 0, pixel_y 0, video_on 0, hsync 1, vsync 1, line_start 0, frame_start 0.
REQ-028 Reset asserted mid-frame aborts the frame immediately with no partial sync pulse after release.
REQ-029 After rst_n deasserts (with en high), the first pixel_tick occurs on the CLK_DIV-th clk.

Structure
REQ-030 Package vga_timing_pkg holds the default timing constants and derived H_TOTAL and V_TOTAL, shared with the display-side modules.
REQ-031 Divider is a sub-module clk_en_div (parameter DIV; inputs clk, rst_n, clr; output tick); the counters and output registers stay in vga_timing_gen.
REQ-032 Counter widths are 10 bits; behaviour with H_TOTAL or V_TOTAL > 1024 is out of scope.

Verification
REQ-033 Reset then en=1, CLK_DIV=4: first pixel_tick on clk 4; pixel_x steps every 4 clks; line_start every 3200 clks; frame_start every 1,680,000 clks.
REQ-034 Sync timing: hsync low for exactly 96 ticks starting at pixel_x=656; vsync low for exactly 2 lines starting at pixel_y=490, hsync keeps running.
REQ-035 video_on: high at (0,0) and (639,479), low at (640,0), (0,480) and (799,524); exactly 307,200 high pixel periods per frame.
REQ-036 Wrap: at (799,524), the next tick gives (0,0) with line_start and frame_start both pulsing for one clk.
REQ-037 Drop en at (300,200) for 10 clks: outputs go to reset values the next clk, no pulses while en is low, and the count restarts at (0,0) with no frame_start.
REQ-038 Assert rst_n mid-hsync: hsync goes high immediately; rerun REQ-033 with CLK_DIV=1 to confirm pixel_tick is high every clk.
